// File: rtl/free_list.sv
// Free-list of shared-memory block indices: a circular index store that self-fills after reset.
// Optional FL_DOUBLE_FREE_CHECK_EN adds an allocated-block bitmap that rejects double frees.
module free_list #(
    parameter int NUM_BLOCKS = 256,
    parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [ADDR_W-1:0] alloc_block_idx_o,
    input  logic              free_req_i,
    input  logic [ADDR_W-1:0] free_block_idx_i,
    output logic [ADDR_W:0]   free_count_o,
    output logic              empty_o,
    output logic              init_done_o,
    output logic              err_o
);
    localparam int                CW        = ADDR_W + 1;
    localparam logic [CW-1:0]     FULL_CNT  = CW'(NUM_BLOCKS);
    localparam logic [CW-1:0]     ZERO_CNT  = {CW{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [ADDR_W-1:0] ZERO_IDX  = {ADDR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] store_q [NUM_BLOCKS];
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic              empty_q, empty_d;
    logic              init_done_q, init_done_d;
    logic              gnt_s;
    logic              free_acc_s;
    logic              dbl_free_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [ADDR_W-1:0] wr_data_s;
`ifdef FL_DOUBLE_FREE_CHECK_EN
    logic [NUM_BLOCKS-1:0] alloc_map_q, alloc_map_d;
`endif

    // Next-state, grant and store-write control.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        init_cnt_d = init_cnt_q;
        count_d    = count_q;
        err_d      = err_q;
        gnt_s      = 1'b0;
        free_acc_s = 1'b0;
        wr_en_s    = 1'b0;
        wr_addr_s  = tail_q;
        wr_data_s  = free_block_idx_i;
`ifdef FL_DOUBLE_FREE_CHECK_EN
        alloc_map_d = alloc_map_q;
        dbl_free_s  = ~alloc_map_q[free_block_idx_i];
`else
        dbl_free_s  = 1'b0;
`endif
        case (state_q)
            ST_INIT: begin
                wr_en_s    = 1'b1;
                wr_addr_s  = init_cnt_q;
                wr_data_s  = init_cnt_q;
                tail_d     = tail_q + ADDR_W'(1);
                count_d    = count_q + CW'(1);
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_INIT;
                end
                if (free_req_i) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            ST_READY: begin
                gnt_s = alloc_req_i & (count_q != ZERO_CNT);
                // Capacity is judged after this cycle's grant, so full+alloc+free is legal.
                if (free_req_i) begin
                    if (((count_q != FULL_CNT) || gnt_s) && !dbl_free_s) begin
                        free_acc_s = 1'b1;
                        wr_en_s    = 1'b1;
                        tail_d     = tail_q + ADDR_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = err_q;
                end
                if (gnt_s) begin
                    head_d = head_q + ADDR_W'(1);
                end else begin
                    head_d = head_q;
                end
                count_d = count_q + CW'(free_acc_s) - CW'(gnt_s);
`ifdef FL_DOUBLE_FREE_CHECK_EN
                if (free_acc_s) begin
                    alloc_map_d[free_block_idx_i] = 1'b0;
                end else begin
                    alloc_map_d = alloc_map_d;
                end
                if (gnt_s) begin
                    alloc_map_d[store_q[head_q]] = 1'b1;
                end else begin
                    alloc_map_d = alloc_map_d;
                end
`endif
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        empty_d     = (state_d == ST_READY) && (count_d == ZERO_CNT);
        init_done_d = (state_d == ST_READY);
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            head_q      <= ZERO_IDX;
            tail_q      <= ZERO_IDX;
            init_cnt_q  <= ZERO_IDX;
            count_q     <= ZERO_CNT;
            err_q       <= 1'b0;
            empty_q     <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            init_cnt_q  <= init_cnt_d;
            count_q     <= count_d;
            err_q       <= err_d;
            empty_q     <= empty_d;
            init_done_q <= init_done_d;
        end
    end

    // Index store; contents are rebuilt by the init sweep so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            store_q[wr_addr_s] <= wr_data_s;
        end
    end

`ifdef FL_DOUBLE_FREE_CHECK_EN
    // Allocated-block bitmap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_map_q <= {NUM_BLOCKS{1'b0}};
        end else begin
            alloc_map_q <= alloc_map_d;
        end
    end
`endif

    assign alloc_gnt_o       = gnt_s;
    assign alloc_block_idx_o = gnt_s ? store_q[head_q] : ZERO_IDX;
    assign free_count_o      = count_q;
    assign empty_o           = empty_q;
    assign init_done_o       = init_done_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list with NUM_BLOCKS=8; expectations are hand-computed.
module tb_free_list;
    localparam int NB = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_req_i = 1'b0;
    logic          alloc_gnt_o;
    logic [AW-1:0] alloc_block_idx_o;
    logic          free_req_i = 1'b0;
    logic [AW-1:0] free_block_idx_i = '0;
    logic [AW:0]   free_count_o;
    logic          empty_o;
    logic          init_done_o;
    logic          err_o;

    int n_checks = 0;
    int n_pass   = 0;

    free_list #(.NUM_BLOCKS(NB), .ADDR_W(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_req_i      (alloc_req_i),
        .alloc_gnt_o      (alloc_gnt_o),
        .alloc_block_idx_o(alloc_block_idx_o),
        .free_req_i       (free_req_i),
        .free_block_idx_i (free_block_idx_i),
        .free_count_o     (free_count_o),
        .empty_o          (empty_o),
        .init_done_o      (init_done_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Advance one clock, then apply this cycle's inputs; outputs are sampled 2 time units after the edge.
    task automatic step(input logic a, input logic f, input int unsigned idx);
        @(posedge clk);
        #1;
        alloc_req_i      = a;
        free_req_i       = f;
        free_block_idx_i = idx[AW-1:0];
        #1;
    endtask

    task automatic expect_gnt(input string tag, input int unsigned idx, input int unsigned cnt);
        check({tag, "_gnt"}, alloc_gnt_o, 1);
        check({tag, "_idx"}, alloc_block_idx_o, idx);
        check({tag, "_cnt"}, free_count_o, cnt);
    endtask

    initial begin
        // Reset state, with an allocate request already pending.
        alloc_req_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", alloc_gnt_o, 0);
        check("rst_cnt", free_count_o, 0);
        check("rst_empty", empty_o, 0);
        check("rst_done", init_done_o, 0);
        check("rst_err", err_o, 0);
        rst_n = 1'b1;

        // Init sweep: 8 cycles, no grants while sweeping.
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 1'b0, 0);
            check("init_gnt", alloc_gnt_o, 0);
            check("init_done", init_done_o, 0);
        end
        check("init_cnt7", free_count_o, 7);

        // Drain: initial grants come out 0..7 on consecutive cycles.
        for (int g = 0; g < NB; g++) begin
            step(1'b1, 1'b0, 0);
            if (g == 0) check("done_rise", init_done_o, 1);
            expect_gnt("drain", g, NB - g);
        end
        step(1'b1, 1'b0, 0);
        check("drained_gnt", alloc_gnt_o, 0);
        check("drained_empty", empty_o, 1);
        check("drained_cnt", free_count_o, 0);

        // Free 5 then 2, then allocate them back in FIFO order.
        step(1'b0, 1'b1, 5); check("f5_cnt", free_count_o, 0);
        step(1'b0, 1'b1, 2); check("f2_cnt", free_count_o, 1);
        step(1'b1, 1'b0, 0); expect_gnt("a5", 5, 2);
        step(1'b1, 1'b0, 0); expect_gnt("a2", 2, 1);
        step(1'b0, 1'b0, 0); check("fifo_cnt0", free_count_o, 0);
        check("fifo_empty", empty_o, 1);

        // Empty pool with same-cycle alloc and free: no bypass.
        step(1'b1, 1'b1, 4);
        check("byp_gnt", alloc_gnt_o, 0);
        step(1'b1, 1'b0, 0); expect_gnt("byp_next", 4, 1);
        step(1'b0, 1'b0, 0); check("byp_cnt0", free_count_o, 0);

        // Three entries queued, then simultaneous alloc + free of 6.
        step(1'b0, 1'b1, 1);
        step(1'b0, 1'b1, 3);
        step(1'b0, 1'b1, 7); check("q3_cnt2", free_count_o, 2);
        step(1'b1, 1'b1, 6); expect_gnt("sim1", 1, 3);
        step(1'b1, 1'b0, 0); expect_gnt("sim3", 3, 3);
        step(1'b1, 1'b0, 0); expect_gnt("sim7", 7, 2);
        step(1'b1, 1'b0, 0); expect_gnt("sim6", 6, 1);
        step(1'b0, 1'b0, 0); check("sim_cnt0", free_count_o, 0);

        // Fill the pool completely.
        for (int i = 0; i < NB; i++) begin
            step(1'b0, 1'b1, i);
        end
        step(1'b0, 1'b0, 0);
        check("full_cnt", free_count_o, 8);
`ifndef FL_DOUBLE_FREE_CHECK_EN
        // Full pool: grant plus free in one cycle is legal.
        step(1'b1, 1'b1, 3); expect_gnt("full_sim", 0, 8);
`endif
        step(1'b0, 1'b1, 1);
        check("ovf_cnt", free_count_o, 8);
        check("ovf_err_pre", err_o, 0);
        step(1'b0, 1'b0, 0);
        check("ovf_err", err_o, 1);
        check("ovf_cnt_hold", free_count_o, 8);

        // Bring count to 3, then reset mid-traffic.
        for (int g = 0; g < 5; g++) begin
            step(1'b1, 1'b0, 0);
            check("pre_rst_gnt", alloc_gnt_o, 1);
        end
        step(1'b1, 1'b0, 0);
        check("pre_rst_cnt", free_count_o, 3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", alloc_gnt_o, 0);
        check("mid_rst_cnt", free_count_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_done", init_done_o, 0);
        step(1'b0, 1'b0, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= NB; k++) begin
            step(1'b0, 1'b0, 0);
            if (k == 7) check("reinit_done7", init_done_o, 0);
        end
        check("reinit_done", init_done_o, 1);
        check("reinit_cnt", free_count_o, 8);

`ifdef FL_DOUBLE_FREE_CHECK_EN
        // Double free of block 0 after a single allocation.
        step(1'b1, 1'b0, 0); expect_gnt("df_alloc", 0, 8);
        step(1'b0, 1'b1, 0); check("df_cnt7", free_count_o, 7);
        step(1'b0, 1'b1, 0); check("df_cnt8", free_count_o, 8);
        check("df_err_pre", err_o, 0);
        step(1'b0, 1'b0, 0);
        check("df_err", err_o, 1);
        check("df_cnt_hold", free_count_o, 8);
`else
        step(1'b1, 1'b0, 0); expect_gnt("reinit_alloc", 0, 8);
        step(1'b0, 1'b0, 0);
        check("reinit_cnt7", free_count_o, 7);
        check("reinit_err", err_o, 0);
`endif

        // Free during the init sweep is ignored and flags an error.
        rst_n = 1'b0;
        step(1'b0, 1'b0, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= NB; k++) begin
            step(1'b0, (k == 1), 2);
            if (k == 2) check("init_free_err", err_o, 1);
        end
        check("init_free_cnt", free_count_o, 8);
        check("init_free_done", init_done_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
